mdu_seq: RTL and testbench

- Iterative RV32M multiply/divide sequencer for the execute stage.
- Accepts one M-extension op (OPC_ARI_RTYPE, funct7 = 0000001) from the decode/ALU path over a valid/ready handshake.
- Runs a shift-add multiply or restoring divide over XLEN cycles, then holds the result until the writeback side takes it.
- The pipeline stall logic uses in_ready/out_valid to freeze the front end while an op is in flight.

---
 rtl/mdu_seq_pkg.sv | 40 ++++
 rtl/mdu_seq_if.sv | 27 ++
 rtl/mdu_div_step.sv | 19 +
 rtl/mdu_seq.sv | 151 +++++++++++++++
 tb/tb_mdu_seq.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/mdu_seq_pkg.sv
// Shared RV32 decode constants for the execute stage: opcodes, M-extension funct codes, sequencer states.
// Latency: none (constants and pure helper functions only).
// Backpressure: n/a.
package mdu_seq_pkg;

  // Opcodes used by the decode/ALU path
  localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;

  // funct7 that routes an R-type op to the multiply/divide sequencer
  localparam logic [6:0] FNC7_MULDIV = 7'b0000001;

  // M-extension funct3 encodings
  localparam logic [2:0] FNC_MUL    = 3'b000;
  localparam logic [2:0] FNC_MULH   = 3'b001;
  localparam logic [2:0] FNC_MULHSU = 3'b010;
  localparam logic [2:0] FNC_MULHU  = 3'b011;
  localparam logic [2:0] FNC_DIV    = 3'b100;
  localparam logic [2:0] FNC_DIVU   = 3'b101;
  localparam logic [2:0] FNC_REM    = 3'b110;
  localparam logic [2:0] FNC_REMU   = 3'b111;

  // Sequencer state encodings
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // rs1 is treated as two's complement for these ops (MUL low half is sign-agnostic)
  function automatic logic fnc_a_signed(input logic [2:0] f);
    return (f == FNC_MULH) || (f == FNC_MULHSU) || (f == FNC_DIV) || (f == FNC_REM);
  endfunction

  // rs2 is treated as two's complement for these ops
  function automatic logic fnc_b_signed(input logic [2:0] f);
    return (f == FNC_MULH) || (f == FNC_DIV) || (f == FNC_REM);
  endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// Issue/result bundle between the decode/ALU path, the multiply/divide sequencer and writeback.
// Latency: none (wires only).
// Backpressure: valid/ready on both the issue side and the result side; kill flushes.
interface mdu_seq_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      funct;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  // Pipeline side: issues ops, consumes results
  modport master (
    output in_valid, funct, rs1, rs2, kill, out_ready,
    input  in_ready, out_valid, result, busy
  );

  // Sequencer side
  modport slave (
    input  in_valid, funct, rs1, rs2, kill, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
// Latency: combinational.
// Backpressure: n/a.
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            dbit,
  input  logic [XLEN-1:0] dvsr,
  output logic [XLEN-1:0] rem_next,
  output logic            qbit
);
  logic [XLEN:0] part;

  assign part = {rem, dbit};
  assign qbit = (part >= {1'b0, dvsr});
  // When the divisor fits the difference is below dvsr, so XLEN-bit modular subtraction is exact
  assign rem_next = qbit ? (part[XLEN-1:0] - dvsr) : part[XLEN-1:0];
endmodule

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer; optional MUL early-out under MDU_EARLY_OUT_EN.
// Latency: XLEN+1 edges accept->out_valid (div-by-zero/overflow: 1 edge; early-out MUL: 2..XLEN+1).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; kill aborts anything.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic   clk,
  input logic   rst,
  mdu_seq_if.slave bus
);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        fn;
  logic              neg_q;     // product/quotient needs negation
  logic              neg_r;     // remainder needs negation (dividend was negative)
  logic              spec_hit;  // result already written at accept
  logic [2*XLEN-1:0] acc;       // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
  logic [XLEN-1:0]   opb;       // MUL: multiplicand magnitude; DIV: divisor magnitude
  logic [XLEN-1:0]   res;

  // Issue-side decode
  logic            accept, a_neg, b_neg, div0, ovf, special, last;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  assign accept   = bus.in_valid && (state == S_IDLE) && !bus.kill;
  assign a_neg    = fnc_a_signed(bus.funct) && bus.rs1[XLEN-1];
  assign b_neg    = fnc_b_signed(bus.funct) && bus.rs2[XLEN-1];
  assign a_mag    = a_neg ? -bus.rs1 : bus.rs1;
  assign b_mag    = b_neg ? -bus.rs2 : bus.rs2;
  assign div0     = bus.funct[2] && (bus.rs2 == '0);
  assign ovf      = bus.funct[2] && !bus.funct[0] && (bus.rs1 == MIN_NEG) && (bus.rs2 == '1);
  assign special  = div0 || ovf;
  assign spec_res = div0 ? (bus.funct[1] ? bus.rs1 : '1) : (bus.funct[1] ? '0 : MIN_NEG);
  assign last     = (cnt == CNT_W'(XLEN - 1));

  // Shift-add step: conditional add into the upper half with carry, then shift right
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
  assign mul_next = {mul_sum, acc[XLEN-1:1]};

  // Restoring-division step; quotient bits shift in behind the consumed dividend bits
  logic [XLEN-1:0]   div_rem;
  logic              div_q;
  logic [2*XLEN-1:0] div_next;
  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .rem      (acc[2*XLEN-1:XLEN]),
    .dbit     (acc[XLEN-1]),
    .dvsr     (opb),
    .rem_next (div_rem),
    .qbit     (div_q)
  );
  assign div_next = {div_rem, acc[XLEN-2:0], div_q};

`ifdef MDU_EARLY_OUT_EN
  // Unconsumed multiplier bits sit in the low XLEN-cnt bits; once they are zero only shifts remain
  logic [XLEN-1:0]   rem_mask;
  logic [CNT_W:0]    rem_cnt;
  logic              mul_idle;
  logic [2*XLEN-1:0] mul_aligned;
  assign rem_mask    = {XLEN{1'b1}} >> cnt;
  assign mul_idle    = ((acc[XLEN-1:0] & rem_mask) == '0);
  assign rem_cnt     = (CNT_W+1)'(XLEN) - {1'b0, cnt};
  assign mul_aligned = acc >> rem_cnt;
`endif

  // Sign correction and half selection applied in FIX
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo, rmd, mul_res, div_res, fix_res;
  assign prod_s  = neg_q ? -acc : acc;
  assign mul_res = (fn == FNC_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
  assign quo     = acc[XLEN-1:0];
  assign rmd     = acc[2*XLEN-1:XLEN];
  assign div_res = fn[1] ? (neg_r ? -rmd : rmd) : (neg_q ? -quo : quo);
  assign fix_res = fn[2] ? div_res : mul_res;

  // Sequencer state, iteration counter and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      fn       <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      spec_hit <= 1'b0;
      acc      <= '0;
      opb      <= '0;
      res      <= '0;
    end else if (bus.kill) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          fn       <= bus.funct;
          neg_q    <= a_neg ^ b_neg;
          neg_r    <= a_neg;
          cnt      <= '0;
          spec_hit <= special;
          opb      <= bus.funct[2] ? b_mag : a_mag;
          acc      <= {{XLEN{1'b0}}, (bus.funct[2] ? a_mag : b_mag)};
          // Special divides skip iteration; FIX leaves their result alone so out_valid lands one edge later
          if (special) begin
            res   <= spec_res;
            state <= S_FIX;
          end else begin
            state <= bus.funct[2] ? S_DIV : S_MUL;
          end
        end
        S_MUL: begin
`ifdef MDU_EARLY_OUT_EN
          if (mul_idle) begin
            acc   <= mul_aligned;
            cnt   <= '0;
            state <= S_FIX;
          end else begin
            acc   <= mul_next;
            cnt   <= last ? '0 : cnt + 1'b1;
            state <= last ? S_FIX : S_MUL;
          end
`else
          acc   <= mul_next;
          cnt   <= last ? '0 : cnt + 1'b1;
          state <= last ? S_FIX : S_MUL;
`endif
        end
        S_DIV: begin
          acc   <= div_next;
          cnt   <= last ? '0 : cnt + 1'b1;
          state <= last ? S_FIX : S_DIV;
        end
        S_FIX: begin
          if (!spec_hit) res <= fix_res;
          state <= S_DONE;
        end
        S_DONE: if (bus.out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
  assign bus.result    = res;
endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: arithmetic results, latencies, special divides, hold, kill and reset.
// Latency: accept->out_valid measured in edges, inputs driven and outputs sampled 1 unit after posedge.
// Backpressure: out_ready held low to check result stability, then pulsed.
module tb_mdu_seq;
  import mdu_seq_pkg::*;

`ifdef MDU_EARLY_OUT_EN
  localparam int LAT_RS2_0 = 2;
  localparam int LAT_RS2_1 = 3;
`else
  localparam int LAT_RS2_0 = 33;
  localparam int LAT_RS2_1 = 33;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  mdu_seq_if #(.XLEN(32)) bus();

  mdu_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.funct    = f;
    bus.rs1      = a;
    bus.rs2      = b;
    chk("in_ready_at_issue", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic release_res();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("in_ready_after_take", {31'b0, bus.in_ready}, 32'd1);
    chk("out_valid_after_take", {31'b0, bus.out_valid}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    start_op(f, a, b);
    wait_done(n);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_res"}, bus.result, exp);
    release_res();
  endtask

  initial begin
    int n;
    int seen;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.funct     = 3'b000;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.kill      = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Multiply family
    run_op("mul_7_m3",     FNC_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mulh_min",     FNC_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("mulhu_2p31",   FNC_MULHU,  32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("mulhsu_m1",    FNC_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33);
    run_op("mul_rs2_0",    FNC_MUL,    32'd12345,    32'd0,        32'd0,        LAT_RS2_0);
    run_op("mul_rs2_1",    FNC_MUL,    32'd12345,    32'd1,        32'd12345,    LAT_RS2_1);

    // Divide family
    run_op("div_m7_2",     FNC_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("rem_m7_2",     FNC_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("divu_100_7",   FNC_DIVU,   32'd100,      32'd7,        32'd14,       33);
    run_op("remu_100_7",   FNC_REMU,   32'd100,      32'd7,        32'd2,        33);

    // Special divides resolved at accept
    run_op("divu_by0",     FNC_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("rem_by0",      FNC_REM,    32'd5,        32'd0,        32'd5,        1);
    run_op("div_ovf",      FNC_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",      FNC_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // Result held while writeback stalls
    start_op(FNC_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(n);
    chk("hold_lat", n, 33);
    chk("hold_res", bus.result, 32'hFFFFFFFE);
    repeat (10) begin
      @(posedge clk); #1;
      chk("hold_result_stable", bus.result, 32'hFFFFFFFE);
      chk("hold_out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("hold_in_ready", {31'b0, bus.in_ready}, 32'd0);
    end
    release_res();

    // kill in the middle of a divide
    start_op(FNC_DIVU, 32'd1000, 32'd3);
    repeat (10) begin @(posedge clk); #1; end
    chk("kill_busy_before", {31'b0, bus.busy}, 32'd1);
    bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    chk("kill_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("kill_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("kill_busy", {31'b0, bus.busy}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen = 1;
    end
    chk("kill_no_output", seen, 0);

    // kill in the accept cycle suppresses the accept
    bus.in_valid = 1'b1;
    bus.kill     = 1'b1;
    bus.funct    = FNC_DIVU;
    bus.rs1      = 32'd100;
    bus.rs2      = 32'd7;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.kill     = 1'b0;
    chk("killacc_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("killacc_busy", {31'b0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    chk("killacc_out_valid", {31'b0, bus.out_valid}, 32'd0);

    // Asynchronous reset in the middle of a multiply
    start_op(FNC_MUL, 32'd7, 32'hFFFFFFFD);
    repeat (5) begin @(posedge clk); #1; end
    chk("rstmid_busy_before", {31'b0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rstmid_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rstmid_busy", {31'b0, bus.busy}, 32'd0);
    chk("rstmid_result", bus.result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Sequencer recovers cleanly afterwards
    run_op("post_divu",    FNC_DIVU,   32'd100,      32'd7,        32'd14,       33);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
